// File: rtl/acc_alu_pkg.sv
// Shared opcode constants and controller state encoding for the accumulator ALU.
package acc_alu_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_LDA = 4'd2;
    localparam logic [3:0] OP_CMA = 4'd3;
    localparam logic [3:0] OP_CIR = 4'd4;
    localparam logic [3:0] OP_CIL = 4'd5;
    localparam logic [3:0] OP_INP = 4'd6;
    localparam logic [3:0] OP_CME = 4'd7;
    localparam logic [3:0] OP_CLE = 4'd8;
    localparam logic [3:0] OP_CLA = 4'd9;
    localparam logic [3:0] OP_INC = 4'd10;

    typedef enum logic {
        ST_IDLE,
        ST_ROTATE
    } state_t;

    function automatic logic is_rot(input logic [3:0] op);
        return (op == OP_CIR) || (op == OP_CIL);
    endfunction

endpackage

// File: rtl/acc_alu_core.sv
// Combinational next-AC/next-E for one operation or one single-position rotate step.
module acc_alu_core
    import acc_alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int INPR_W = 8
) (
    input  logic [3:0]        op,
    input  logic [WIDTH-1:0]  ac,
    input  logic              e,
    input  logic [WIDTH-1:0]  dr,
    input  logic [INPR_W-1:0] inpr,
    output logic [WIDTH-1:0]  ac_nxt,
    output logic              e_nxt
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] inc_sum;

    // Carry-out lands in the top bit and becomes the new E.
    assign add_sum = {1'b0, ac} + {1'b0, dr};
    assign inc_sum = {1'b0, ac} + (WIDTH+1)'(1);

    always_comb begin
        ac_nxt = ac;
        e_nxt  = e;
        case (op)
            OP_AND: ac_nxt = ac & dr;
            OP_ADD: {e_nxt, ac_nxt} = add_sum;
            OP_LDA: ac_nxt = dr;
            OP_CMA: ac_nxt = ~ac;
            OP_CIR: begin
                ac_nxt = {e, ac[WIDTH-1:1]};
                e_nxt  = ac[0];
            end
            OP_CIL: begin
                ac_nxt = {ac[WIDTH-2:0], e};
                e_nxt  = ac[WIDTH-1];
            end
            OP_INP: ac_nxt = WIDTH'(inpr);
            OP_CME: e_nxt = ~e;
            OP_CLE: e_nxt = 1'b0;
            OP_CLA: ac_nxt = '0;
            OP_INC: {e_nxt, ac_nxt} = inc_sum;
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_alu.sv
// Accumulator ALU: single-cycle ops plus multi-cycle {E,AC} rotates sequenced by an IDLE/ROTATE FSM.
module acc_alu
    import acc_alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int INPR_W  = 8,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   dr_in,
    input  logic [INPR_W-1:0]  inpr_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   ac_out,
    output logic               e_out,
    output logic               zero_flag,
    output logic               neg_flag,
    output logic               done
);

    state_t             state, state_nxt;
    logic [SHAMT_W-1:0] cnt, cnt_nxt;
    logic               done_nxt;
    logic [3:0]         rot_op;
    logic [3:0]         core_op;
    logic               load;
    logic               accept;
    logic [WIDTH-1:0]   ac, ac_nxt;
    logic               e, e_nxt;

    assign op_ready  = (state == ST_IDLE);
    assign accept    = op_valid && op_ready;
    assign ac_out    = ac;
    assign e_out     = e;
    assign zero_flag = (ac == '0);
    assign neg_flag  = ac[WIDTH-1];

    acc_alu_core #(.WIDTH(WIDTH), .INPR_W(INPR_W)) u_core (
        .op     (core_op),
        .ac     (ac),
        .e      (e),
        .dr     (dr_in),
        .inpr   (inpr_in),
        .ac_nxt (ac_nxt),
        .e_nxt  (e_nxt)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        core_op   = op;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    load = 1'b1;
                    // First step runs on the accept edge; cnt holds the steps still owed.
                    if (is_rot(op) && (shamt > SHAMT_W'(1))) begin
                        state_nxt = ST_ROTATE;
                        cnt_nxt   = shamt - SHAMT_W'(1);
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ST_ROTATE: begin
                core_op = rot_op;
                load    = 1'b1;
                cnt_nxt = cnt - SHAMT_W'(1);
                if (cnt == SHAMT_W'(1)) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ac     <= '0;
            e      <= 1'b0;
            rot_op <= OP_CIR;
        end else begin
            if (load) begin
                ac <= ac_nxt;
                e  <= e_nxt;
            end
            if (accept)
                rot_op <= op;
        end
    end

endmodule

// File: tb/tb_acc_alu.sv
// Directed-vector self-checking bench for acc_alu (WIDTH=16, INPR_W=8, SHAMT_W=4).
module tb_acc_alu;
    import acc_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  op = '0;
    logic [15:0] dr_in = '0;
    logic [7:0]  inpr_in = '0;
    logic [3:0]  shamt = '0;
    logic [15:0] ac_out;
    logic        e_out, zero_flag, neg_flag, done;

    int total = 0;
    int bad   = 0;

    acc_alu #(.WIDTH(16), .INPR_W(8), .SHAMT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op        (op),
        .dr_in     (dr_in),
        .inpr_in   (inpr_in),
        .shamt     (shamt),
        .ac_out    (ac_out),
        .e_out     (e_out),
        .zero_flag (zero_flag),
        .neg_flag  (neg_flag),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one op for a single accept edge; returns 1 time unit after that edge.
    task automatic issue(input logic [3:0] o, input logic [15:0] d, input logic [7:0] ip,
                         input logic [3:0] sh);
        op_valid = 1'b1;
        op       = o;
        dr_in    = d;
        inpr_in  = ip;
        shamt    = sh;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ac", 32'(ac_out), 32'h0);
        chk("rst_e", 32'(e_out), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ready", 32'(op_ready), 32'h1);
        chk("rst_zero", 32'(zero_flag), 32'h1);
        chk("rst_neg", 32'(neg_flag), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ADD with carry-out
        issue(OP_LDA, 16'hFFFF, 8'h00, 4'd0);
        issue(OP_CLE, 16'h0000, 8'h00, 4'd0);
        issue(OP_ADD, 16'h0001, 8'h00, 4'd0);
        chk("add_ac", 32'(ac_out), 32'h0000);
        chk("add_e", 32'(e_out), 32'h1);
        chk("add_zero", 32'(zero_flag), 32'h1);
        chk("add_done", 32'(done), 32'h1);
        tick();
        chk("add_done_drop", 32'(done), 32'h0);

        // Back-to-back INP, CMA, CME (E enters as 1)
        issue(OP_INP, 16'h0000, 8'hA5, 4'd0);
        chk("inp_ac", 32'(ac_out), 32'h00A5);
        chk("inp_e", 32'(e_out), 32'h1);
        chk("inp_done", 32'(done), 32'h1);
        issue(OP_CMA, 16'h0000, 8'h00, 4'd0);
        chk("cma_ac", 32'(ac_out), 32'hFF5A);
        chk("cma_neg", 32'(neg_flag), 32'h1);
        chk("cma_done", 32'(done), 32'h1);
        issue(OP_CME, 16'h0000, 8'h00, 4'd0);
        chk("cme_e", 32'(e_out), 32'h0);
        chk("cme_ac", 32'(ac_out), 32'hFF5A);
        chk("cme_done", 32'(done), 32'h1);
        tick();
        chk("cme_done_drop", 32'(done), 32'h0);

        // CIL shamt=3, with a CLA request held during the rotate that must be ignored
        issue(OP_LDA, 16'h8001, 8'h00, 4'd0);
        issue(OP_CLE, 16'h0000, 8'h00, 4'd0);
        issue(OP_CIL, 16'h0000, 8'h00, 4'd3);
        op_valid = 1'b1;
        op       = OP_CLA;
        chk("cil1_ac", 32'(ac_out), 32'h0002);
        chk("cil1_e", 32'(e_out), 32'h1);
        chk("cil1_ready", 32'(op_ready), 32'h0);
        chk("cil1_done", 32'(done), 32'h0);
        tick();
        chk("cil2_ac", 32'(ac_out), 32'h0005);
        chk("cil2_e", 32'(e_out), 32'h0);
        chk("cil2_ready", 32'(op_ready), 32'h0);
        chk("cil2_done", 32'(done), 32'h0);
        tick();
        op_valid = 1'b0;
        chk("cil3_ac", 32'(ac_out), 32'h000A);
        chk("cil3_e", 32'(e_out), 32'h0);
        chk("cil3_ready", 32'(op_ready), 32'h1);
        chk("cil3_done", 32'(done), 32'h1);
        tick();
        chk("cil_done_drop", 32'(done), 32'h0);
        chk("cil_ac_hold", 32'(ac_out), 32'h000A);

        // CIR shamt=0 behaves as one step
        issue(OP_LDA, 16'h1234, 8'h00, 4'd0);
        issue(OP_CIR, 16'h0000, 8'h00, 4'd0);
        chk("cir0_ac", 32'(ac_out), 32'h091A);
        chk("cir0_e", 32'(e_out), 32'h0);
        chk("cir0_done", 32'(done), 32'h1);
        chk("cir0_ready", 32'(op_ready), 32'h1);

        // Remaining single-cycle ops
        issue(OP_ADD, 16'h0F00, 8'h00, 4'd0);
        chk("add2_ac", 32'(ac_out), 32'h181A);
        chk("add2_e", 32'(e_out), 32'h0);
        issue(OP_INC, 16'h0000, 8'h00, 4'd0);
        chk("inc_ac", 32'(ac_out), 32'h181B);
        issue(OP_AND, 16'h00FF, 8'h00, 4'd0);
        chk("and_ac", 32'(ac_out), 32'h001B);
        issue(OP_CME, 16'h0000, 8'h00, 4'd0);
        issue(4'd13, 16'hFFFF, 8'hFF, 4'd0);
        chk("nop_ac", 32'(ac_out), 32'h001B);
        chk("nop_e", 32'(e_out), 32'h1);
        chk("nop_done", 32'(done), 32'h1);
        issue(OP_CLA, 16'h0000, 8'h00, 4'd0);
        chk("cla_ac", 32'(ac_out), 32'h0000);
        chk("cla_e", 32'(e_out), 32'h1);
        chk("cla_zero", 32'(zero_flag), 32'h1);
        issue(OP_LDA, 16'hFFFF, 8'h00, 4'd0);
        issue(OP_INC, 16'h0000, 8'h00, 4'd0);
        chk("inc_wrap_ac", 32'(ac_out), 32'h0000);
        chk("inc_wrap_e", 32'(e_out), 32'h1);

        // CIR shamt=15 aborted by reset mid-rotate
        issue(OP_LDA, 16'h00F0, 8'h00, 4'd0);
        issue(OP_CIR, 16'h0000, 8'h00, 4'd15);
        for (int i = 0; i < 4; i++) begin
            chk("abort_busy", 32'(op_ready), 32'h0);
            chk("abort_nodone", 32'(done), 32'h0);
            tick();
        end
        rst = 1'b1;
        #1;
        chk("abort_ac", 32'(ac_out), 32'h0);
        chk("abort_e", 32'(e_out), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_ready", 32'(op_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", 32'(done), 32'h0);
        issue(OP_LDA, 16'h00FF, 8'h00, 4'd0);
        chk("post_rst_lda_ac", 32'(ac_out), 32'h00FF);
        chk("post_rst_lda_done", 32'(done), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
